// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD-to-binary converter: FSM states and digit validity.
// No timing behaviour of its own; purely declarations.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_digit_ok(input logic [3:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + d using shifts and adds, truncated to BIN_W.
// Zero latency, no flow control.
module bcd_mac10 #(
    parameter int BIN_W = 7
) (
    input  logic [BIN_W-1:0] acc_i,
    input  logic [3:0]       d_i,
    output logic [BIN_W-1:0] acc_o
);

    assign acc_o = (acc_i << 3) + (acc_i << 1) + BIN_W'(d_i);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Packed BCD to binary, one digit per clock MSD first; result valid DIGITS edges after accept.
// Result held while out_ready=0; a new word is taken in the same cycle as the output handshake.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      out_bin,
    output logic                  out_err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   sr_q, sr_d;
    logic [BIN_W-1:0]      acc_q, acc_d;
    logic                  err_q, err_d;
    logic [BIN_W-1:0]      bin_q, bin_d;
    logic                  oerr_q, oerr_d;

    logic [3:0]            digit;
    logic [BIN_W-1:0]      mac_acc;
    logic                  accept;

    assign digit = sr_q[4*DIGITS-1 -: 4];

    bcd_mac10 #(.BIN_W(BIN_W)) u_mac10 (
        .acc_i (acc_q),
        .d_i   (digit),
        .acc_o (mac_acc)
    );

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out_bin   = bin_q;
    assign out_err   = oerr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        err_d   = err_q;
        bin_d   = bin_q;
        oerr_d  = oerr_q;

        case (state_q)
            IDLE: ;
            CONV: begin
                acc_d = mac_acc;
                err_d = err_q || !bcd_digit_ok(digit);
                sr_d  = sr_q << 4;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    // Invalid digits can overflow the accumulator, so the result is forced to 0.
                    bin_d   = err_d ? '0 : acc_d;
                    oerr_d  = err_d;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // accept is never true in CONV, so this only overrides IDLE/DONE decisions.
        if (accept) begin
            state_d = CONV;
            sr_d    = in_bcd;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            bin_q   <= '0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            bin_q   <= bin_d;
            oerr_q  <= oerr_d;
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: directed literal cases plus randomized traffic against a behavioural model.
// Two instances: DIGITS=2/BIN_W=7 (model-checked) and DIGITS=4/BIN_W=14 (directed only).
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 2;
    localparam int BIN_W  = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [7:0]        in_bcd = 8'h00;
    logic              in_ready, out_valid, out_err;
    logic [BIN_W-1:0]  out_bin;

    logic              b_in_valid = 1'b0;
    logic              b_out_ready = 1'b0;
    logic [15:0]       b_in_bcd = 16'h0000;
    logic              b_in_ready, b_out_valid, b_out_err;
    logic [13:0]       b_out_bin;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err)
    );

    bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_bcd    (b_in_bcd),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_bin   (b_out_bin),
        .out_err   (b_out_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference conversion: plain decimal arithmetic over the nibbles.
    function automatic void ref_conv(input logic [7:0] w, output int v, output bit e);
        int acc;
        acc = 0;
        e   = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (w[4*i +: 4] > 4'd9) e = 1'b1;
            acc = acc * 10 + int'(w[4*i +: 4]);
        end
        v = e ? 0 : acc;
    endfunction

    // Model: cycles left until a result appears, and the pending result itself.
    bit m_init  = 1'b0;
    int m_cnt   = 0;
    bit m_valid = 1'b0;
    int m_val   = 0;
    bit m_err   = 1'b0;
    bit m_acc;

    function automatic bit model_ready(input bit ordy);
        return (m_cnt == 0) && (!m_valid || ordy);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt   = 0;
            m_valid = 1'b0;
            m_init  = 1'b1;
        end else if (m_init) begin
            m_acc = in_valid && model_ready(out_ready);
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_valid = 1'b1;
            end
            if (m_acc) begin
                m_cnt = DIGITS;
                ref_conv(in_bcd, m_val, m_err);
            end
        end
    end

    always @(negedge clk) begin
        if (m_init && !rst) begin
            chk("model in_ready", in_ready, model_ready(out_ready));
            chk("model out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("model out_bin", out_bin, m_val);
                chk("model out_err", out_err, m_err);
            end
        end
    end

    task automatic send2(input logic [7:0] w, input bit ordy, input int exp_bin,
                         input bit exp_err, input string nm);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; in_bcd = w; out_ready = ordy;
        @(posedge clk); #1;
        in_valid = 1'b0; in_bcd = 8'hEE;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, DIGITS);
        chk({nm, " out_bin"}, out_bin, exp_bin);
        chk({nm, " out_err"}, out_err, exp_err);
    endtask

    task automatic send4(input logic [15:0] w, input int exp_bin, input bit exp_err,
                         input string nm);
        int lat;
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_in_bcd = w; b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, 4);
        chk({nm, " out_bin"}, b_out_bin, exp_bin);
        chk({nm, " out_err"}, b_out_err, exp_err);
    endtask

    function automatic logic [7:0] rand_word();
        logic [7:0] w;
        for (int i = 0; i < DIGITS; i++) begin
            if ($urandom_range(0, 3) == 0) w[4*i +: 4] = 4'($urandom_range(0, 15));
            else                           w[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return w;
    endfunction

    initial begin
        int t0, spacing, seen;

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_bin", out_bin, 0);
        chk("reset out_err", out_err, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset4 out_valid", b_out_valid, 0);
        rst = 1'b0;

        send2(8'h42, 1'b1, 42, 1'b0, "bcd42");
        send2(8'h99, 1'b1, 99, 1'b0, "bcd99");
        send2(8'h00, 1'b1, 0, 1'b0, "bcd00");
        send2(8'h3A, 1'b1, 0, 1'b1, "bcd3A");
        send2(8'hF0, 1'b1, 0, 1'b1, "bcdF0");
        send2(8'h17, 1'b1, 17, 1'b0, "bcd17");

        send4(16'h9999, 9999, 1'b0, "bcd9999");
        send4(16'h1234, 1234, 1'b0, "bcd1234");
        send4(16'h12C4, 0, 1'b1, "bcd12C4");
        @(posedge clk); #1;

        // Backpressure: result must hold for 5 stalled cycles.
        send2(8'h56, 1'b0, 56, 1'b0, "bcd56");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold out_valid", out_valid, 1);
            chk("hold out_bin", out_bin, 56);
            chk("hold in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release out_valid", out_valid, 0);
        chk("release in_ready", in_ready, 1);

        // Back-to-back: second word accepted on the first output handshake.
        in_valid = 1'b1; in_bcd = 8'h12; out_ready = 1'b1;
        @(posedge clk); #1;
        in_bcd = 8'h34;
        seen = 0;
        while (!out_valid && seen < 20) begin @(posedge clk); #1; seen++; end
        chk("b2b first out_bin", out_bin, 12);
        chk("b2b accept with handshake", in_ready, 1);
        t0 = $time;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b out_valid drops", out_valid, 0);
        seen = 0;
        while (!out_valid && seen < 20) begin @(posedge clk); #1; seen++; end
        spacing = ($time - t0) / 10;
        chk("b2b spacing", spacing, DIGITS + 1);
        chk("b2b second out_bin", out_bin, 34);
        @(posedge clk); #1;

        // Reset mid-conversion discards the word.
        in_valid = 1'b1; in_bcd = 8'h88;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("rst no output", seen, 0);
        send2(8'h05, 1'b1, 5, 1'b0, "bcd05");

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_bcd    = rand_word();
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drain out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
